// File: rtl/stopwatch_seq_ctrl.sv
// Stopwatch sequencer: tick prescaler, run/lap/pause FSM, BCD ripple enables.
// Optional macro STOPWATCH_AUTO_WRAP_EN: wrap on overflow instead of DONE.
module stopwatch_seq_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1000000,
  parameter int DIV_W      = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_stop,
  input  logic                  lap,
  input  logic                  clear,
  input  logic [NUM_DIGITS-1:0] digit_eq_9,
  output logic [NUM_DIGITS-1:0] digit_inc,
  output logic                  digit_clr,
  output logic                  running,
  output logic                  freeze,
  output logic                  overflow
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_LAP   = 3'd2,
`ifndef STOPWATCH_AUTO_WRAP_EN
    S_DONE  = 3'd4,
`endif
    S_PAUSE = 3'd3
  } state_e;

  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             clr_q, clr_d;
  logic             active;
  logic             tick;
  logic             all9;
  logic             carry;

  // Tick generation and ripple-carry enables for the digit cascade
  always_comb begin
    active    = (state_q == S_RUN) || (state_q == S_LAP);
    tick      = active && (presc_q == PRESC_MAX);
    all9      = &digit_eq_9;
    digit_inc = '0;
    carry     = tick;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_inc[i] = carry;
      carry        = carry & digit_eq_9[i];
    end
  end

  // Next state, prescaler and clear pulse; clear > start_stop > lap
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    presc_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (clear) clr_d = 1'b1;
        else if (start_stop) state_d = S_RUN;
      end
      S_RUN: begin
`ifndef STOPWATCH_AUTO_WRAP_EN
        if (tick && all9) state_d = S_DONE;
        else
`endif
        if (start_stop) state_d = S_PAUSE;
        else if (lap) state_d = S_LAP;
      end
      S_LAP: begin
`ifndef STOPWATCH_AUTO_WRAP_EN
        if (tick && all9) state_d = S_DONE;
        else
`endif
        if (start_stop) state_d = S_PAUSE;
        else if (lap) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (clear) begin
          clr_d   = 1'b1;
          state_d = S_IDLE;
        end else if (start_stop) begin
          state_d = S_RUN;
        end
      end
`ifndef STOPWATCH_AUTO_WRAP_EN
      S_DONE: begin
        if (clear) begin
          clr_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Prescaler follows the current state; pause keeps the partial tick
    unique case (state_q)
      S_RUN, S_LAP: presc_d = tick ? '0 : presc_q + DIV_W'(1);
      S_PAUSE:      presc_d = presc_q;
      default:      presc_d = '0;
    endcase
  end

  // State, prescaler and clear pulse registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      clr_q   <= clr_d;
    end
  end

`ifdef STOPWATCH_AUTO_WRAP_EN
  logic ovf_q, ovf_d;

  // One-cycle overflow pulse after the cascade wraps
  always_comb begin
    ovf_d = tick & all9;
  end

  // Overflow pulse register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = (state_q == S_DONE);
`endif

  assign running   = active;
  assign freeze    = (state_q == S_LAP);
  assign digit_clr = ~reset | clr_q;

endmodule

// File: tb/tb_stopwatch_seq_ctrl.sv
// Scoreboard bench for stopwatch_seq_ctrl (2 digits, tick every 4 cycles).
// digit_inc events are queued by stimulus and popped by a monitor.
module tb_stopwatch_seq_ctrl;

  localparam int ND = 2;
  localparam int TD = 4;
  localparam int DW = 2;

  typedef struct {
    int         cyc;
    logic [1:0] inc;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start_stop = 1'b0;
  logic          lap = 1'b0;
  logic          clear = 1'b0;
  logic [ND-1:0] digit_eq_9 = '0;
  logic [ND-1:0] digit_inc;
  logic          digit_clr;
  logic          running;
  logic          freeze;
  logic          overflow;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t e;
  int   b, p, f;

  stopwatch_seq_ctrl #(
    .NUM_DIGITS(ND),
    .TICK_DIV  (TD),
    .DIV_W     (DW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start_stop(start_stop),
    .lap       (lap),
    .clear     (clear),
    .digit_eq_9(digit_eq_9),
    .digit_inc (digit_inc),
    .digit_clr (digit_clr),
    .running   (running),
    .freeze    (freeze),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL inc_missed cyc=%0d want=%b at cyc %0d",
               cyc, e.inc, e.cyc);
    end
    if (reset && digit_inc != 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL inc_unexpected cyc=%0d got=%b want=none",
                 cyc, digit_inc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.inc != digit_inc) begin
          errors++;
          $display("FAIL inc got=%b@%0d want=%b@%0d",
                   digit_inc, cyc, e.inc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d want=finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    step();
    lap = 1'b0;
  endtask

  task automatic pulse_clr();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic push(input int c, input logic [1:0] v);
    exp_t x;
    x.cyc = c;
    x.inc = v;
    exp_q.push_back(x);
  endtask

  initial begin
    #1;
    chk("rst_inc", digit_inc, 2'b00);
    chk("rst_clr", {1'b0, digit_clr}, 2'b01);
    chk("rst_run", {1'b0, running}, 2'b00);
    chk("rst_frz", {1'b0, freeze}, 2'b00);
    chk("rst_ovf", {1'b0, overflow}, 2'b00);
    step();
    step();
    reset = 1'b1;
    step();
    chk("idle_clr", {1'b0, digit_clr}, 2'b00);
    chk("idle_run", {1'b0, running}, 2'b00);

    pulse_ss();
    b = cyc;
    chk("start_run", {1'b0, running}, 2'b01);
    push(b + 3, 2'b01);
    push(b + 7, 2'b11);
    push(b + 11, 2'b01);
    wait_to(b + 4);
    digit_eq_9 = 2'b01;
    wait_to(b + 8);
    digit_eq_9 = 2'b10;
    wait_to(b + 12);
    digit_eq_9 = 2'b00;

    wait_to(b + 13);
    pulse_ss();
    chk("pause_run", {1'b0, running}, 2'b00);
    wait_to(b + 20);
    pulse_ss();
    p = cyc;
    chk("resume_run", {1'b0, running}, 2'b01);
    push(p + 1, 2'b01);

    wait_to(p + 2);
    pulse_lap();
    chk("lap_frz", {1'b0, freeze}, 2'b01);
    chk("lap_run", {1'b0, running}, 2'b01);
    push(p + 5, 2'b01);
    wait_to(p + 6);
    pulse_lap();
    chk("unlap_frz", {1'b0, freeze}, 2'b00);
    pulse_clr();
    chk("run_clr_ign", {1'b0, digit_clr}, 2'b00);
    chk("run_clr_run", {1'b0, running}, 2'b01);
    push(p + 9, 2'b01);
    wait_to(p + 10);

    digit_eq_9 = 2'b11;
    push(p + 13, 2'b11);
    wait_to(p + 14);
`ifdef STOPWATCH_AUTO_WRAP_EN
    chk("wrap_ovf", {1'b0, overflow}, 2'b01);
    chk("wrap_run", {1'b0, running}, 2'b01);
    digit_eq_9 = 2'b00;
    step();
    chk("wrap_ovf_end", {1'b0, overflow}, 2'b00);
    push(p + 17, 2'b01);
    wait_to(p + 18);
`else
    chk("done_ovf", {1'b0, overflow}, 2'b01);
    chk("done_run", {1'b0, running}, 2'b00);
    pulse_ss();
    chk("done_ss_ign", {1'b0, running}, 2'b00);
    wait_to(p + 20);
    pulse_clr();
    chk("done_clr", {1'b0, digit_clr}, 2'b01);
    chk("done_ovf_end", {1'b0, overflow}, 2'b00);
    chk("done_idle", {1'b0, running}, 2'b00);
    step();
    chk("clr_pulse_end", {1'b0, digit_clr}, 2'b00);
    digit_eq_9 = 2'b00;
    pulse_ss();
`endif

    step();
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_inc", digit_inc, 2'b00);
    chk("mid_rst_clr", {1'b0, digit_clr}, 2'b01);
    chk("mid_rst_run", {1'b0, running}, 2'b00);
    chk("mid_rst_frz", {1'b0, freeze}, 2'b00);
    chk("mid_rst_ovf", {1'b0, overflow}, 2'b00);
    step();
    reset = 1'b1;
    step();
    pulse_ss();
    f = cyc;
    push(f + 3, 2'b01);
    wait_to(f + 5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
